// File: rtl/pc_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_ctrl_pkg
//  Purpose  : Shared definitions for the fetch sequencer: datapath width,
//             timeout counter width, FSM state encoding and the PC control
//             bundle with its priority helper.
//  Revision : 1.0  initial release
// ============================================================================
package pc_fetch_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_INIT   = 3'd0;
  localparam state_t ST_REQ    = 3'd1;
  localparam state_t ST_WAIT   = 3'd2;
  localparam state_t ST_HOLD   = 3'd3;
  localparam state_t ST_HALTED = 3'd4;

  // Control strobes toward the program counter.
  typedef struct packed {
    logic clear;
    logic write;
    logic inc;
  } pc_ctrl_t;

  // Collapse raw requests so at most one strobe reaches the PC:
  // clear beats write, write beats inc.
  function automatic pc_ctrl_t pc_ctrl_prio(input pc_ctrl_t raw);
    pc_ctrl_t res;
    res = '0;
    if (raw.clear) begin
      res.clear = 1'b1;
    end else if (raw.write) begin
      res.write = 1'b1;
    end else if (raw.inc) begin
      res.inc = 1'b1;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_ctrl_if
//  Purpose  : Bundles every non-clock/reset signal of the fetch sequencer.
//  Ports    : PC control   - pc_in, pc_clear, pc_write, pc_inc, pc_load_val
//             Instr memory - imem_req, imem_addr, imem_gnt, imem_rvalid,
//                            imem_rdata
//             Decode       - ir_valid, ir_data, ir_pc, ir_ready
//             Control      - br_taken, br_target, halt, fault, state
//  Modports : master - the fetch sequencer
//             slave  - the surrounding PC / memory / decode environment
//  Revision : 1.0  initial release
// ============================================================================
interface pc_fetch_ctrl_if;
  import pc_fetch_ctrl_pkg::*;

  logic [DATA_W-1:0] pc_in;
  logic              pc_clear;
  logic              pc_write;
  logic              pc_inc;
  logic [DATA_W-1:0] pc_load_val;

  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;

  logic              ir_valid;
  logic [DATA_W-1:0] ir_data;
  logic [DATA_W-1:0] ir_pc;
  logic              ir_ready;

  logic              br_taken;
  logic [DATA_W-1:0] br_target;
  logic              halt;
  logic              fault;
  logic [2:0]        state;

  modport master (
    input  pc_in, imem_gnt, imem_rvalid, imem_rdata, ir_ready,
           br_taken, br_target, halt,
    output pc_clear, pc_write, pc_inc, pc_load_val, imem_req, imem_addr,
           ir_valid, ir_data, ir_pc, fault, state
  );

  modport slave (
    output pc_in, imem_gnt, imem_rvalid, imem_rdata, ir_ready,
           br_taken, br_target, halt,
    input  pc_clear, pc_write, pc_inc, pc_load_val, imem_req, imem_addr,
           ir_valid, ir_data, ir_pc, fault, state
  );

endinterface
`default_nettype wire

// File: rtl/fetch_timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_timeout_cnt
//  Purpose  : Counts cycles spent waiting for an instruction-memory response
//             and flags the cycle in which the count sits at TIMEOUT-1.
//  Ports    : clk   - system clock
//             reset - asynchronous active-low reset
//             clr   - synchronous clear (start of a new wait)
//             en    - count this cycle (sequencer is waiting)
//             tc    - terminal count reached while enabled
//  Revision : 1.0  initial release
// ============================================================================
module fetch_timeout_cnt #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] c_tc_val = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Only meaningful while waiting; TIMEOUT <= 255 keeps the count from wrapping.
  assign tc = en && (r_count == c_tc_val);

endmodule
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_ctrl
//  Purpose  : Fetch sequencer. Drives the program-counter control strobes,
//             runs a request/grant/response fetch to instruction memory and
//             holds the fetched word for decode under valid/ready. Handles
//             branch redirects (squashing fetches in flight), halt requests
//             and a sticky response-timeout fault.
//  Ports    : clk   - system clock, rising edge
//             reset - asynchronous active-low reset
//             bus   - pc_fetch_ctrl_if.master (PC, memory, decode, control)
//  Revision : 1.0  initial release
// ============================================================================
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  pc_fetch_ctrl_if.master bus
);

  state_t            r_state;
  state_t            w_next_state;

  logic              r_squash;
  logic              r_halt_pend;
  logic              r_fault;
  logic              r_ir_valid;
  logic [DATA_W-1:0] r_ir_data;
  logic [DATA_W-1:0] r_ir_pc;

  logic              w_tc;
  logic              w_cnt_clr;
  logic              w_cnt_en;

  logic              w_capture;
  logic              w_ir_release;
  logic              w_imem_req;
  pc_ctrl_t          w_pc_raw;
  pc_ctrl_t          w_pc_ctrl;

  // --------------------------------------------------------------------------
  // Wait-cycle counter
  // --------------------------------------------------------------------------
  assign w_cnt_en  = (r_state == ST_WAIT);
  assign w_cnt_clr = (r_state == ST_REQ) && (w_next_state == ST_WAIT);

  fetch_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (w_cnt_clr),
    .en    (w_cnt_en),
    .tc    (w_tc)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_INIT: begin
        w_next_state = ST_REQ;
      end
      ST_REQ: begin
        // A redirect re-issues from the new PC, so it outranks halt and grant.
        if (bus.br_taken) begin
          w_next_state = ST_REQ;
        end else if (bus.halt || r_halt_pend) begin
          w_next_state = ST_HALTED;
        end else if (bus.imem_gnt) begin
          w_next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.imem_rvalid) begin
          // Squashed or coincident-redirect responses are dropped.
          w_next_state = (r_squash || bus.br_taken) ? ST_REQ : ST_HOLD;
        end else if (w_tc) begin
          w_next_state = ST_HALTED;
        end
      end
      ST_HOLD: begin
        if (bus.br_taken || bus.ir_ready) begin
          w_next_state = ST_REQ;
        end
      end
      ST_HALTED: begin
        w_next_state = ST_HALTED;
      end
      default: begin
        w_next_state = ST_INIT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_pc_raw     = '0;
    w_imem_req   = 1'b0;
    w_capture    = 1'b0;
    w_ir_release = 1'b0;
    case (r_state)
      ST_INIT: begin
        // Gated by reset so every strobe is low while reset is held.
        w_pc_raw.clear = reset;
      end
      ST_REQ: begin
        w_pc_raw.write = bus.br_taken;
        w_imem_req     = !bus.br_taken && !bus.halt && !r_halt_pend;
      end
      ST_WAIT: begin
        w_pc_raw.write = bus.br_taken;
        w_capture      = bus.imem_rvalid && !r_squash && !bus.br_taken;
        w_pc_raw.inc   = w_capture;
      end
      ST_HOLD: begin
        w_pc_raw.write = bus.br_taken;
        w_ir_release   = bus.br_taken || bus.ir_ready;
      end
      default: begin
        w_pc_raw = '0;
      end
    endcase
  end

  assign w_pc_ctrl = pc_ctrl_prio(w_pc_raw);

  // --------------------------------------------------------------------------
  // Squash / halt / fault flags and the instruction hold register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_squash    <= 1'b0;
      r_halt_pend <= 1'b0;
      r_fault     <= 1'b0;
      r_ir_valid  <= 1'b0;
      r_ir_data   <= '0;
      r_ir_pc     <= '0;
    end else begin
      if (r_state == ST_WAIT) begin
        if (bus.imem_rvalid) begin
          r_squash <= 1'b0;
        end else if (bus.br_taken) begin
          r_squash <= 1'b1;
        end
      end

      if (bus.halt && ((r_state == ST_WAIT) || (r_state == ST_HOLD))) begin
        r_halt_pend <= 1'b1;
      end

      if (w_tc && !bus.imem_rvalid) begin
        r_fault <= 1'b1;
      end

      if (w_capture) begin
        r_ir_valid <= 1'b1;
        r_ir_data  <= bus.imem_rdata;
        r_ir_pc    <= bus.pc_in;  // PC has not yet taken this cycle's increment
      end else if (w_ir_release) begin
        r_ir_valid <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.pc_clear    = w_pc_ctrl.clear;
  assign bus.pc_write    = w_pc_ctrl.write;
  assign bus.pc_inc      = w_pc_ctrl.inc;
  assign bus.pc_load_val = bus.br_target;
  assign bus.imem_req    = w_imem_req;
  assign bus.imem_addr   = bus.pc_in;
  assign bus.ir_valid    = r_ir_valid;
  assign bus.ir_data     = r_ir_data;
  assign bus.ir_pc       = r_ir_pc;
  assign bus.fault       = r_fault;
  assign bus.state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_fetch_ctrl
//  Purpose  : Directed self-checking bench for pc_fetch_ctrl. Includes a
//             behavioural program counter that obeys the clear/write/inc
//             strobes; memory and decode responses are driven step by step.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_fetch_ctrl;
  import pc_fetch_ctrl_pkg::*;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_reg = 32'hDEAD_BEEF;
  int          total = 0;
  int          bad   = 0;

  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl #(
    .TIMEOUT (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Program counter owned by the environment.
  assign bus.pc_in = pc_reg;
  always @(posedge clk) begin
    if (bus.pc_clear)      pc_reg <= 32'h0;
    else if (bus.pc_write) pc_reg <= bus.pc_load_val;
    else if (bus.pc_inc)   pc_reg <= pc_reg + 32'h1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.ir_ready    = 1'b0;
    bus.br_taken    = 1'b0;
    bus.br_target   = 32'h0;
    bus.halt        = 1'b0;
  endtask

  // One fetch: grant in REQ, one empty WAIT cycle, response on the second
  // WAIT cycle, then 'stall' HOLD cycles with ir_ready low before acceptance.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int stall);
    idle();
    bus.imem_gnt = 1'b1;
    #1;
    chk("req_state", bus.state, 32'd1);
    chk("req_req", bus.imem_req, 32'd1);
    chk("req_addr", bus.imem_addr, addr);
    next_cycle(); idle(); #1;
    chk("wait_state", bus.state, 32'd2);
    chk("wait_noreq", bus.imem_req, 32'd0);
    next_cycle(); idle();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = data;
    #1;
    chk("resp_inc", bus.pc_inc, 32'd1);
    chk("resp_nowrite", bus.pc_write, 32'd0);
    next_cycle(); idle();
    for (int i = 0; i < stall; i++) begin
      #1;
      chk("stall_state", bus.state, 32'd3);
      chk("stall_valid", bus.ir_valid, 32'd1);
      chk("stall_data", bus.ir_data, data);
      chk("stall_noreq", bus.imem_req, 32'd0);
      next_cycle(); idle();
    end
    bus.ir_ready = 1'b1;
    #1;
    chk("hold_valid", bus.ir_valid, 32'd1);
    chk("hold_data", bus.ir_data, data);
    chk("hold_pc", bus.ir_pc, addr);
    chk("hold_noinc", bus.pc_inc, 32'd0);
    next_cycle(); idle();
  endtask

  initial begin
    idle();
    // ---- reset held ----
    #1;
    chk("rst_state", bus.state, 32'd0);
    chk("rst_clear", bus.pc_clear, 32'd0);
    chk("rst_req", bus.imem_req, 32'd0);
    chk("rst_valid", bus.ir_valid, 32'd0);
    chk("rst_fault", bus.fault, 32'd0);
    next_cycle(); next_cycle();

    // ---- release: one-cycle clear, then sequential fetches ----
    reset = 1'b1;
    #1;
    chk("init_state", bus.state, 32'd0);
    chk("init_clear", bus.pc_clear, 32'd1);
    chk("init_noreq", bus.imem_req, 32'd0);
    next_cycle();
    chk("clear_once", bus.pc_clear, 32'd0);
    fetch(32'h0, 32'h1000_0000, 0);
    fetch(32'h1, 32'h1000_0001, 0);
    fetch(32'h2, 32'h1000_0002, 0);

    // ---- decode stalls for 5 cycles ----
    fetch(32'h3, 32'h1000_0003, 5);

    // ---- redirect while waiting ----
    bus.imem_gnt = 1'b1;
    #1;
    chk("br_wait_addr", bus.imem_addr, 32'h4);
    next_cycle(); idle();
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h40;
    #1;
    chk("br_wait_write", bus.pc_write, 32'd1);
    chk("br_wait_loadval", bus.pc_load_val, 32'h40);
    chk("br_wait_noinc", bus.pc_inc, 32'd0);
    next_cycle(); idle();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBAD0_0004;
    #1;
    chk("squash_noinc", bus.pc_inc, 32'd0);
    next_cycle(); idle(); #1;
    chk("squash_state", bus.state, 32'd1);
    chk("squash_valid", bus.ir_valid, 32'd0);
    chk("squash_addr", bus.imem_addr, 32'h40);
    fetch(32'h40, 32'h2000_0040, 0);

    // ---- redirect coinciding with the response ----
    bus.imem_gnt = 1'b1;
    #1;
    chk("brr_addr", bus.imem_addr, 32'h41);
    next_cycle(); idle();
    bus.br_taken    = 1'b1;
    bus.br_target   = 32'h80;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBAD0_0041;
    #1;
    chk("brr_write", bus.pc_write, 32'd1);
    chk("brr_noinc", bus.pc_inc, 32'd0);
    next_cycle(); idle(); #1;
    chk("brr_state", bus.state, 32'd1);
    chk("brr_valid", bus.ir_valid, 32'd0);
    chk("brr_addr2", bus.imem_addr, 32'h80);

    // ---- redirect coinciding with ir_ready in HOLD ----
    bus.imem_gnt = 1'b1;
    #1; next_cycle(); idle(); #1;
    next_cycle(); idle();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h3000_0080;
    #1; next_cycle(); idle();
    bus.ir_ready  = 1'b1;
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h100;
    #1;
    chk("brh_state", bus.state, 32'd3);
    chk("brh_write", bus.pc_write, 32'd1);
    chk("brh_noinc", bus.pc_inc, 32'd0);
    next_cycle(); idle(); #1;
    chk("brh_valid", bus.ir_valid, 32'd0);
    chk("brh_state2", bus.state, 32'd1);
    chk("brh_addr", bus.imem_addr, 32'h100);

    // ---- halt while holding ----
    bus.imem_gnt = 1'b1;
    #1; next_cycle(); idle(); #1;
    next_cycle(); idle();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h4000_0100;
    #1; next_cycle(); idle();
    bus.halt = 1'b1;
    #1;
    chk("halt_hold_state", bus.state, 32'd3);
    chk("halt_hold_valid", bus.ir_valid, 32'd1);
    next_cycle(); idle();
    bus.ir_ready = 1'b1;
    #1;
    chk("halt_deliver_data", bus.ir_data, 32'h4000_0100);
    chk("halt_deliver_pc", bus.ir_pc, 32'h100);
    next_cycle(); idle(); #1;
    chk("halt_req_state", bus.state, 32'd1);
    chk("halt_req_noreq", bus.imem_req, 32'd0);
    next_cycle(); #1;
    chk("halted_state", bus.state, 32'd4);
    chk("halted_noreq", bus.imem_req, 32'd0);
    chk("halted_valid", bus.ir_valid, 32'd0);
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h5;
    #1;
    chk("halted_br_nowrite", bus.pc_write, 32'd0);
    next_cycle(); idle(); #1;
    chk("halted_stays", bus.state, 32'd4);

    // ---- response timeout ----
    reset = 1'b0;
    #1;
    chk("rst2_state", bus.state, 32'd0);
    next_cycle();
    reset = 1'b1;
    #1;
    chk("rst2_clear", bus.pc_clear, 32'd1);
    next_cycle();
    bus.imem_gnt = 1'b1;
    #1;
    chk("to_addr", bus.imem_addr, 32'h0);
    next_cycle(); idle();
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("to_wait_state", bus.state, 32'd2);
      chk("to_wait_nofault", bus.fault, 32'd0);
      next_cycle();
    end
    #1;
    chk("to_state", bus.state, 32'd4);
    chk("to_fault", bus.fault, 32'd1);
    chk("to_noreq", bus.imem_req, 32'd0);
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h200;
    bus.imem_gnt  = 1'b1;
    #1;
    chk("to_br_nowrite", bus.pc_write, 32'd0);
    chk("to_br_noclear", bus.pc_clear, 32'd0);
    chk("to_br_noinc", bus.pc_inc, 32'd0);
    next_cycle(); idle(); #1;
    chk("to_noreq2", bus.imem_req, 32'd0);
    chk("to_fault_sticky", bus.fault, 32'd1);

    // ---- asynchronous reset clears the fault immediately ----
    reset = 1'b0;
    #1;
    chk("arst_fault", bus.fault, 32'd0);
    chk("arst_state", bus.state, 32'd0);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    fetch(32'h0, 32'h5555_AAAA, 0);

    // ---- asynchronous reset in the middle of WAIT ----
    bus.imem_gnt = 1'b1;
    #1; next_cycle(); idle(); #1;
    chk("mid_wait_state", bus.state, 32'd2);
    chk("mid_wait_data", bus.ir_data, 32'h5555_AAAA);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_state", bus.state, 32'd0);
    chk("mid_rst_data", bus.ir_data, 32'h0);
    chk("mid_rst_pc", bus.ir_pc, 32'h0);
    chk("mid_rst_valid", bus.ir_valid, 32'd0);
    chk("mid_rst_req", bus.imem_req, 32'd0);
    chk("mid_rst_clear", bus.pc_clear, 32'd0);
    chk("mid_rst_write", bus.pc_write, 32'd0);
    chk("mid_rst_inc", bus.pc_inc, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
